ks_data_path_param: RTL and testbench

Parametrised K&S processor datapath: program counter, instruction register, decoder, NUM_REGS-entry register file, 8-function ALU and flags register, all with generic data width, register count and memory address width. It sits between the K&S control unit, which drives every enable and select, and the single-port program/data RAM. It adds a synchronous reset of all state, illegal-opcode detection, three-bit ALU operation select (XOR, shifts, pass-through) and a PC observation port.

---
 rtl/ks_data_path_param.sv | 173 +++++++++++++++++
 tb/tb_ks_data_path_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_data_path_param.sv
// K&S processor datapath: PC, IR, decoder, NUM_REGS x DATA_W register file,
// 8-function ALU and registered flags. The control unit drives every strobe;
// the single-port RAM sees ram_addr/data_out and returns data_in.
// Ports: clk/rst_n (sync, active-low); control strobes branch, pc_enable,
// ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable, operation[2:0];
// data_in (RAM read data); decoded_instruction[3:0] (NOP=0 LOAD=1 STORE=2
// MOVE=3 ADD=4 SUB=5 AND=6 OR=7 BRANCH=8 BZERO=9 BNEG=10 HALT=11),
// illegal_instr, zero_op/neg_op/unsigned_overflow/signed_overflow,
// ram_addr, data_out (= register a), pc_out.
module ks_data_path_param #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch,
    input  logic              pc_enable,
    input  logic              ir_enable,
    input  logic              addr_sel,
    input  logic              c_sel,
    input  logic              write_reg_enable,
    input  logic              flags_reg_enable,
    input  logic [2:0]        operation,
    input  logic [DATA_W-1:0] data_in,
    output logic [3:0]        decoded_instruction,
    output logic              illegal_instr,
    output logic              zero_op,
    output logic              neg_op,
    output logic              unsigned_overflow,
    output logic              signed_overflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] pc_out
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int M  = DATA_W - 1;

    localparam logic [3:0] I_NOP    = 4'd0;
    localparam logic [3:0] I_LOAD   = 4'd1;
    localparam logic [3:0] I_STORE  = 4'd2;
    localparam logic [3:0] I_MOVE   = 4'd3;
    localparam logic [3:0] I_ADD    = 4'd4;
    localparam logic [3:0] I_SUB    = 4'd5;
    localparam logic [3:0] I_AND    = 4'd6;
    localparam logic [3:0] I_OR     = 4'd7;
    localparam logic [3:0] I_BRANCH = 4'd8;
    localparam logic [3:0] I_BZERO  = 4'd9;
    localparam logic [3:0] I_BNEG   = 4'd10;
    localparam logic [3:0] I_HALT   = 4'd11;

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] mem_addr;
    logic [RW-1:0]     sel_a, sel_b, sel_c;
    logic [DATA_W-1:0] bus_a, bus_b, alu_out;
    logic [DATA_W:0]   wide;
    logic              alu_zero, alu_neg, alu_uovf, alu_sovf;
    logic              unused_ir_bits;

    assign opcode         = ir[DATA_W-1 -: 8];
    assign unused_ir_bits = ^ir;

    // Decode: fields an opcode does not use stay 0, so an unused c field
    // still selects r0 if the control unit strobes a write anyway.
    always_comb begin
        decoded_instruction = I_NOP;
        illegal_instr       = 1'b0;
        mem_addr            = '0;
        sel_a               = '0;
        sel_b               = '0;
        sel_c               = '0;
        case (opcode)
            8'h81: begin
                decoded_instruction = I_LOAD;
                mem_addr            = ir[ADDR_W-1:0];
                sel_c               = ir[ADDR_W+RW-1:ADDR_W];
            end
            8'h82: begin
                decoded_instruction = I_STORE;
                mem_addr            = ir[ADDR_W-1:0];
                sel_a               = ir[ADDR_W+RW-1:ADDR_W];
            end
            8'h91: begin
                decoded_instruction = I_MOVE;
                sel_a               = ir[RW-1:0];
                sel_b               = ir[RW-1:0];
                sel_c               = ir[2*RW-1:RW];
            end
            8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
                case (opcode[2:0])
                    3'd1:    decoded_instruction = I_ADD;
                    3'd2:    decoded_instruction = I_SUB;
                    3'd3:    decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                sel_a = ir[RW-1:0];
                sel_b = ir[2*RW-1:RW];
                sel_c = ir[3*RW-1:2*RW];
            end
            8'h01: begin decoded_instruction = I_BRANCH; mem_addr = ir[ADDR_W-1:0]; end
            8'h02: begin decoded_instruction = I_BZERO;  mem_addr = ir[ADDR_W-1:0]; end
            8'h03: begin decoded_instruction = I_BNEG;   mem_addr = ir[ADDR_W-1:0]; end
            8'h00: decoded_instruction = I_NOP;
            8'hFF: decoded_instruction = I_HALT;
            default: illegal_instr = 1'b1;
        endcase
    end

    assign bus_a    = regs[sel_a];
    assign bus_b    = regs[sel_b];
    assign data_out = bus_a;
    assign ram_addr = addr_sel ? mem_addr : pc;
    assign pc_out   = pc;

    // ALU; the extra bit of 'wide' is carry-out on ADD and borrow on SUB.
    always_comb begin
        wide     = '0;
        alu_out  = '0;
        alu_uovf = 1'b0;
        alu_sovf = 1'b0;
        case (operation)
            3'b000: alu_out = bus_a | bus_b;
            3'b001: begin
                wide     = {1'b0, bus_a} + {1'b0, bus_b};
                alu_out  = wide[DATA_W-1:0];
                alu_uovf = wide[DATA_W];
                alu_sovf = (bus_a[M] == bus_b[M]) && (alu_out[M] != bus_a[M]);
            end
            3'b010: begin
                wide     = {1'b0, bus_a} - {1'b0, bus_b};
                alu_out  = wide[DATA_W-1:0];
                alu_uovf = wide[DATA_W];
                alu_sovf = (bus_a[M] != bus_b[M]) && (alu_out[M] != bus_a[M]);
            end
            3'b011: alu_out = bus_a & bus_b;
            3'b100: alu_out = bus_a ^ bus_b;
            3'b101: begin
                alu_out  = {bus_a[M-1:0], 1'b0};
                alu_uovf = bus_a[M];
                alu_sovf = bus_a[M] ^ bus_a[M-1];
            end
            3'b110:  alu_out = {1'b0, bus_a[M:1]};
            default: alu_out = bus_a;
        endcase
        alu_zero = (alu_out == '0);
        alu_neg  = alu_out[M];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc                <= '0;
            ir                <= '0;
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (pc_enable) pc <= branch ? mem_addr : pc + ADDR_W'(1);
            if (ir_enable) ir <= data_in;
            if (write_reg_enable) regs[sel_c] <= c_sel ? data_in : alu_out;
            if (flags_reg_enable) begin
                zero_op           <= alu_zero;
                neg_op            <= alu_neg;
                unsigned_overflow <= alu_uovf;
                signed_overflow   <= alu_sovf;
            end
        end
    end
endmodule

// File: tb/tb_ks_data_path_param.sv
module tb_ks_data_path_param;
    localparam int DATA_W = 16;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n, branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic write_reg_enable, flags_reg_enable;
    logic [2:0] operation;
    logic [DATA_W-1:0] data_in;
    logic [3:0] decoded_instruction;
    logic illegal_instr, zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [ADDR_W-1:0] ram_addr, pc_out;
    logic [DATA_W-1:0] data_out;

    int vectors = 0;
    int errs = 0;

    // Reference state
    int m_pc, m_ir;
    int m_r [NUM_REGS];
    int m_z, m_n, m_uo, m_so;

    logic [7:0] opl [14];

    ks_data_path_param #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
        .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
        .operation(operation), .data_in(data_in),
        .decoded_instruction(decoded_instruction), .illegal_instr(illegal_instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
        .signed_overflow(signed_overflow), .ram_addr(ram_addr),
        .data_out(data_out), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        vectors++;
        assert (obs_v === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    // Opcode table: returns decode code, illegal flag, and the fields.
    task automatic mdecode(input int ir, output int code, output int ill,
                           output int ma, output int fa, output int fb, output int fc);
        int opc, lo, mid, hi, ld, addr;
        opc  = ir / 256;
        addr = ir % (1 << ADDR_W);
        lo   = ir % NUM_REGS;
        mid  = (ir / NUM_REGS) % NUM_REGS;
        hi   = (ir / (NUM_REGS * NUM_REGS)) % NUM_REGS;
        ld   = (ir / (1 << ADDR_W)) % NUM_REGS;
        code = 0; ill = 0; ma = 0; fa = 0; fb = 0; fc = 0;
        case (opc)
            'h81: begin code = 1; ma = addr; fc = ld; end
            'h82: begin code = 2; ma = addr; fa = ld; end
            'h91: begin code = 3; fa = lo; fb = lo; fc = mid; end
            'hA1: begin code = 4; fa = lo; fb = mid; fc = hi; end
            'hA2: begin code = 5; fa = lo; fb = mid; fc = hi; end
            'hA3: begin code = 6; fa = lo; fb = mid; fc = hi; end
            'hA4: begin code = 7; fa = lo; fb = mid; fc = hi; end
            'h01: begin code = 8; ma = addr; end
            'h02: begin code = 9; ma = addr; end
            'h03: begin code = 10; ma = addr; end
            'h00: code = 0;
            'hFF: code = 11;
            default: ill = 1;
        endcase
    endtask

    function automatic int sgn(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic int out_of_range(input int v);
        return (v > 32767 || v < -32768) ? 1 : 0;
    endfunction

    task automatic malu(input int op, input int a, input int b, output int res,
                        output int z, output int n, output int uo, output int so);
        uo = 0; so = 0;
        case (op)
            0: res = a | b;
            1: begin res = (a + b) % 65536; uo = (a + b > 65535); so = out_of_range(sgn(a) + sgn(b)); end
            2: begin res = (a - b + 65536) % 65536; uo = (a < b); so = out_of_range(sgn(a) - sgn(b)); end
            3: res = a & b;
            4: res = a ^ b;
            5: begin res = (a * 2) % 65536; uo = (a >= 32768); so = out_of_range(sgn(a) * 2); end
            6: res = a / 2;
            default: res = a;
        endcase
        z = (res == 0);
        n = (res >= 32768);
    endtask

    task automatic check_model();
        int code, ill, ma, fa, fb, fc;
        mdecode(m_ir, code, ill, ma, fa, fb, fc);
        chk("pc_out", 32'(pc_out), m_pc);
        chk("ram_addr", 32'(ram_addr), addr_sel ? ma : m_pc);
        chk("data_out", 32'(data_out), m_r[fa]);
        chk("decoded", 32'(decoded_instruction), code);
        chk("illegal", 32'(illegal_instr), ill);
        chk("zero", 32'(zero_op), m_z);
        chk("neg", 32'(neg_op), m_n);
        chk("uovf", 32'(unsigned_overflow), m_uo);
        chk("sovf", 32'(signed_overflow), m_so);
    endtask

    // One clock: the model advances from the inputs held across the edge.
    task automatic tick();
        int code, ill, ma, fa, fb, fc, res, z, n, uo, so;
        int n_pc, n_ir, n_z, n_n, n_uo, n_so, wr_idx, wr_val, do_wr;
        mdecode(m_ir, code, ill, ma, fa, fb, fc);
        malu(int'(operation), m_r[fa], m_r[fb], res, z, n, uo, so);
        n_pc = m_pc; n_ir = m_ir; n_z = m_z; n_n = m_n; n_uo = m_uo; n_so = m_so;
        do_wr = 0; wr_idx = fc; wr_val = c_sel ? int'(data_in) : res;
        if (!rst_n) begin
            n_pc = 0; n_ir = 0; n_z = 0; n_n = 0; n_uo = 0; n_so = 0;
        end else begin
            if (pc_enable) n_pc = branch ? ma : (m_pc + 1) % (1 << ADDR_W);
            if (ir_enable) n_ir = int'(data_in);
            if (write_reg_enable) do_wr = 1;
            if (flags_reg_enable) begin n_z = z; n_n = n; n_uo = uo; n_so = so; end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ir = n_ir; m_z = n_z; m_n = n_n; m_uo = n_uo; m_so = n_so;
        if (!rst_n) for (int i = 0; i < NUM_REGS; i++) m_r[i] = 0;
        else if (do_wr != 0) m_r[wr_idx] = wr_val;
        check_model();
    endtask

    task automatic set_ir(input logic [15:0] v);
        data_in = v; ir_enable = 1'b1;
        tick();
        ir_enable = 1'b0;
    endtask

    task automatic load_reg(input int k, input logic [15:0] v);
        set_ir(16'h8100 | 16'(k << ADDR_W));
        data_in = v; c_sel = 1'b1; write_reg_enable = 1'b1;
        tick();
        c_sel = 1'b0; write_reg_enable = 1'b0;
    endtask

    initial begin
        opl = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                8'h01, 8'h02, 8'h03, 8'h00, 8'hFF, 8'h55, 8'h10};
        rst_n = 1'b0; branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0;
        c_sel = 0; write_reg_enable = 0; flags_reg_enable = 0; operation = 0; data_in = 0;
        m_pc = 0; m_ir = 0; m_z = 0; m_n = 0; m_uo = 0; m_so = 0;
        for (int i = 0; i < NUM_REGS; i++) m_r[i] = 0;
        tick(); tick();
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_dec", 32'(decoded_instruction), 0);
        chk("rst_ill", 32'(illegal_instr), 0);
        chk("rst_flags", {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 0);
        rst_n = 1'b1;

        // PC increments
        pc_enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("pc_inc", 32'(pc_out), i);
        end
        pc_enable = 1'b0;
        chk("ram_addr_pc", 32'(ram_addr), 3);

        // LOAD then STORE
        set_ir(16'h8107);
        data_in = 16'h1234; c_sel = 1; write_reg_enable = 1;
        tick();
        c_sel = 0; write_reg_enable = 0;
        set_ir(16'h8209);
        addr_sel = 1'b1; #1;
        chk("store_addr", 32'(ram_addr), 9);
        chk("store_data", 32'(data_out), 32'h1234);
        addr_sel = 1'b0;

        // ADD with signed overflow into r3
        load_reg(1, 16'h7FFF);
        load_reg(2, 16'h0001);
        set_ir(16'hA139);
        operation = 3'b001; write_reg_enable = 1; flags_reg_enable = 1;
        tick();
        write_reg_enable = 0; flags_reg_enable = 0;
        chk("add_flags", {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'b0101);
        set_ir(16'h8260);
        chk("add_r3", 32'(data_out), 32'h8000);

        // SUB 0-1 then AND to zero
        load_reg(1, 16'h0000);
        set_ir(16'hA239);
        operation = 3'b010; write_reg_enable = 1; flags_reg_enable = 1;
        tick();
        write_reg_enable = 0; flags_reg_enable = 0;
        chk("sub_flags", {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'b0110);
        set_ir(16'hA339);
        operation = 3'b011; flags_reg_enable = 1;
        tick();
        flags_reg_enable = 0;
        chk("and_flags", {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'b1000);

        // Branch and wrap
        set_ir(16'h0113);
        branch = 1; pc_enable = 1;
        tick();
        branch = 0;
        chk("branch_pc", 32'(pc_out), 32'h13);
        for (int i = 0; i < 12; i++) tick();
        chk("pc_max", 32'(pc_out), 31);
        tick();
        pc_enable = 0;
        chk("pc_wrap", 32'(pc_out), 0);

        // Illegal opcode, then reset in the middle of a write strobe
        set_ir(16'h5500);
        chk("illegal_dec", 32'(decoded_instruction), 0);
        chk("illegal_flag", 32'(illegal_instr), 1);
        set_ir(16'hA139);
        operation = 3'b001; write_reg_enable = 1; flags_reg_enable = 1; rst_n = 0;
        tick();
        rst_n = 1; write_reg_enable = 0; flags_reg_enable = 0;
        chk("rst_mid_flags", {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 0);
        chk("rst_mid_ill", 32'(illegal_instr), 0);
        for (int k = 0; k < NUM_REGS; k++) begin
            set_ir(16'h8200 | 16'(k << ADDR_W));
            chk("rst_mid_reg", 32'(data_out), 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_n            = ($urandom_range(0, 59) != 0);
            branch           = 1'($urandom);
            pc_enable        = 1'($urandom);
            ir_enable        = ($urandom_range(0, 3) == 0);
            addr_sel         = 1'($urandom);
            c_sel            = 1'($urandom);
            write_reg_enable = 1'($urandom);
            flags_reg_enable = 1'($urandom);
            operation        = 3'($urandom);
            data_in          = 16'($urandom);
            if (ir_enable) data_in = {opl[$urandom_range(0, 13)], 8'($urandom)};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
